// File: rtl/gb_pkg.sv
// Shared Game Boy core constants and the OAM DMA state encoding.
package gb_pkg;
   localparam logic [15:0] DMA_REG_ADDR   = 16'hFF46;
   localparam logic [15:0] OAM_BASE       = 16'hFE00;
   localparam int          OAM_LEN        = 160;
   localparam logic [7:0]  ECHO_BASE_PAGE = 8'hE0;

   typedef enum logic [1:0] {IDLE, START, XFER, LAST} dma_state_t;

   // Echo RAM ($E000-$FDFF) aliases work RAM at $C000-$DDFF.
   function automatic logic [7:0] map_page(input logic [7:0] page);
      return (page >= ECHO_BASE_PAGE) ? page - 8'h20 : page;
   endfunction
endpackage

// File: rtl/oam_dma_if.sv
// CPU register port, source read bus and OAM write bus of the sprite DMA.
interface oam_dma_if;
   logic        cpu_sel;
   logic        cpu_wr;
   logic [7:0]  cpu_di;
   logic [7:0]  cpu_do;
   logic        src_rd;
   logic [15:0] src_addr;
   logic [7:0]  src_data;
   logic        oam_wr;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_data;
   logic        busy;

   modport master (
      input  cpu_sel, cpu_wr, cpu_di, src_data,
      output cpu_do, src_rd, src_addr, oam_wr, oam_addr, oam_data, busy
   );

   modport slave (
      output cpu_sel, cpu_wr, cpu_di, src_data,
      input  cpu_do, src_rd, src_addr, oam_wr, oam_addr, oam_data, busy
   );
endinterface

// File: rtl/oam_dma_ctr.sv
// Start-delay counter, byte index and pending-restart slot for the OAM DMA.
module oam_dma_ctr
   import gb_pkg::*;
#(
   parameter int LEN         = OAM_LEN,
   parameter int START_DELAY = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic       wr,
   input  logic [7:0] wr_data,
   input  dma_state_t state,
   output logic [7:0] page,
   output logic [7:0] idx,
   output logic       dly_done,
   output logic       fire,
   output logic       pend,
   output logic       last_idx
);
   localparam logic [7:0] DLY      = 8'(START_DELAY);
   localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

   logic [7:0] cnt;
   logic [7:0] pcnt;
   logic [7:0] ppage;

   assign dly_done = (state == START) && ce && (cnt <= 8'd1);
   // A write on the same clk supersedes whatever was pending.
   assign fire     = (state == XFER) && ce && pend && (pcnt <= 8'd1) && !wr;
   assign last_idx = (idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         pcnt  <= '0;
         ppage <= '0;
         page  <= '0;
         idx   <= '0;
         pend  <= 1'b0;
      end else begin
         if (state == START && ce && cnt != 8'd0)
            cnt <= cnt - 8'd1;
         if (state == XFER && ce) begin
            if (fire) begin
               idx  <= '0;
               page <= ppage;
               pend <= 1'b0;
            end else begin
               idx <= idx + 8'd1;
               if (pend && pcnt != 8'd0)
                  pcnt <= pcnt - 8'd1;
            end
         end
         // Pending request outlived the old transfer: hand its remaining delay to START.
         if (state == LAST && pend) begin
            page <= ppage;
            cnt  <= pcnt;
            idx  <= '0;
            pend <= 1'b0;
         end
         if (wr) begin
            if (state == XFER) begin
               ppage <= wr_data;
               pcnt  <= DLY;
               pend  <= 1'b1;
            end else begin
               page <= wr_data;
               cnt  <= DLY;
               idx  <= '0;
               pend <= 1'b0;
            end
         end
      end
   end
endmodule

// File: rtl/oam_dma.sv
// Sprite-attribute DMA: copies LEN bytes from page XX00 into OAM, one per ce.
module oam_dma
   import gb_pkg::*;
#(
   parameter int LEN         = OAM_LEN,
   parameter int START_DELAY = 1
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      ce,
   oam_dma_if.master bus
);
   localparam dma_state_t ARM = (START_DELAY == 0) ? XFER : START;

   dma_state_t state, state_nx;
   logic       wr;
   logic [7:0] page, idx;
   logic       dly_done, fire, pend, last_idx;
   logic       src_rd;
   logic       own;
   logic       oam_wr;
   logic [7:0] oam_addr;
   logic [7:0] cpu_reg;

   assign wr = bus.cpu_sel && bus.cpu_wr;

   oam_dma_ctr #(.LEN(LEN), .START_DELAY(START_DELAY)) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .ce       (ce),
      .wr       (wr),
      .wr_data  (bus.cpu_di),
      .state    (state),
      .page     (page),
      .idx      (idx),
      .dly_done (dly_done),
      .fire     (fire),
      .pend     (pend),
      .last_idx (last_idx)
   );

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (wr) state_nx = ARM;
         START: begin
            if (wr)            state_nx = ARM;
            else if (dly_done) state_nx = XFER;
         end
         XFER:  if (ce && last_idx && !fire) state_nx = (pend || wr) ? LAST : IDLE;
         LAST:  state_nx = ARM;
         default: state_nx = IDLE;
      endcase
   end

   assign src_rd = (state == XFER) && ce;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         own      <= 1'b0;
         oam_wr   <= 1'b0;
         oam_addr <= '0;
         cpu_reg  <= 8'hFF;
      end else begin
         state <= state_nx;
         // Bus ownership spans restarts; only a return to IDLE releases it.
         own    <= (state_nx == IDLE) ? 1'b0 : (own | src_rd);
         oam_wr <= src_rd;
         if (src_rd) oam_addr <= idx;
         if (wr)     cpu_reg  <= bus.cpu_di;
      end
   end

   assign bus.src_rd   = src_rd;
   assign bus.src_addr = src_rd ? {map_page(page), idx} : 16'h0000;
   assign bus.oam_wr   = oam_wr;
   assign bus.oam_addr = oam_addr;
   assign bus.oam_data = oam_wr ? bus.src_data : 8'h00;
   assign bus.busy     = src_rd | own | oam_wr;
   assign bus.cpu_do   = cpu_reg;
endmodule
